// File: rtl/mem_lsu.sv
// Load/store unit between EX/MEM and a word-only data memory.
// Loads are extracted from the combinational read word; sb/sh become a stall-then-merge read-modify-write.
module mem_lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_we,
   input  logic [31:0] mem_dout,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic        err_valid,
   output logic [31:0] err_addr
);

   // state | meaning
   // IDLE  | accept requests; loads, sw and illegal requests complete in one cycle
   // MERGE | write old_word merged with the held sb/sh data; req_* ignored

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] old_word;
   logic [31:0] rmw_addr;
   logic [15:0] rmw_wdata;
   logic        rmw_half;

   logic        funct3_ok;
   logic        align_ok;
   logic        legal;
   logic        active;
   logic        do_load;
   logic        do_sw;
   logic        do_rmw;

   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_word;

   logic [3:0]  lane_mask;
   logic [31:0] bit_mask;
   logic [31:0] lane_data;
   logic [31:0] merged;

   // Unsigned sub-word variants exist only for loads.
   always_comb begin
      funct3_ok = 1'b0;
      case (req_funct3)
         F3_B, F3_H, F3_W: funct3_ok = 1'b1;
         F3_BU, F3_HU:     funct3_ok = !req_we;
         default:          funct3_ok = 1'b0;
      endcase
   end

   always_comb begin
      align_ok = 1'b0;
      case (req_funct3[1:0])
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = !req_addr[0];
         2'b10:   align_ok = (req_addr[1:0] == 2'b00);
         default: align_ok = 1'b0;
      endcase
   end

   assign legal   = funct3_ok && align_ok;
   assign active  = (state == IDLE) && req_valid;
   assign do_load = active && legal && !req_we;
   assign do_sw   = active && legal && req_we && (req_funct3[1:0] == 2'b10);
   assign do_rmw  = active && legal && req_we && (req_funct3[1:0] != 2'b10);

   always_comb begin
      load_byte = mem_dout[7:0];
      case (req_addr[1:0])
         2'b00:   load_byte = mem_dout[7:0];
         2'b01:   load_byte = mem_dout[15:8];
         2'b10:   load_byte = mem_dout[23:16];
         default: load_byte = mem_dout[31:24];
      endcase
      load_half = req_addr[1] ? mem_dout[31:16] : mem_dout[15:0];
      load_word = mem_dout;
      case (req_funct3)
         F3_B:    load_word = {{24{load_byte[7]}}, load_byte};
         F3_H:    load_word = {{16{load_half[15]}}, load_half};
         F3_BU:   load_word = {24'h000000, load_byte};
         F3_HU:   load_word = {16'h0000, load_half};
         default: load_word = mem_dout;
      endcase
   end

   // Replicate the store data into every lane, then pick lanes with a byte mask.
   always_comb begin
      if (rmw_half) begin
         lane_mask = rmw_addr[1] ? 4'b1100 : 4'b0011;
         lane_data = {2{rmw_wdata}};
      end else begin
         lane_mask = 4'b0001 << rmw_addr[1:0];
         lane_data = {4{rmw_wdata[7:0]}};
      end
      bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
      merged   = (old_word & ~bit_mask) | (lane_data & bit_mask);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = do_rmw ? MERGE : IDLE;
         MERGE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stall    = 1'b0;
      mem_we   = 1'b0;
      mem_addr = req_addr;
      mem_din  = req_wdata;
      case (state)
         IDLE: begin
            stall  = do_rmw;
            mem_we = do_sw;
         end
         MERGE: begin
            mem_addr = rmw_addr;
            mem_din  = merged;
            mem_we   = 1'b1;
         end
         default: begin
            stall  = 1'b0;
            mem_we = 1'b0;
         end
      endcase
      // Reset must never let a half-finished merge reach memory.
      if (!rst_n) begin
         stall  = 1'b0;
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         old_word  <= 32'h0;
         rmw_addr  <= 32'h0;
         rmw_wdata <= 16'h0;
         rmw_half  <= 1'b0;
      end else if (do_rmw) begin
         old_word  <= mem_dout;
         rmw_addr  <= req_addr;
         rmw_wdata <= req_wdata[15:0];
         rmw_half  <= req_funct3[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid  <= 1'b0;
         wb_data   <= 32'h0;
         err_valid <= 1'b0;
         err_addr  <= 32'h0;
      end else begin
         wb_valid  <= 1'b0;
         err_valid <= 1'b0;
         if (active && !legal) begin
            err_valid <= 1'b1;
            err_addr  <= req_addr;
         end else if (do_load) begin
            wb_valid <= 1'b1;
            wb_data  <= load_word;
         end
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-addressed reference memory model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_mem_lsu;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_we;
   logic [31:0] mem_dout;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic        err_valid;
   logic [31:0] err_addr;

   int errors = 0;
   int checks = 0;

   mem_lsu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_we     (mem_we),
      .mem_dout   (mem_dout),
      .wb_valid   (wb_valid),
      .wb_data    (wb_data),
      .err_valid  (err_valid),
      .err_addr   (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-only data memory: combinational read, falling-edge write.
   logic [31:0] mem [0:65535];
   assign mem_dout = mem[mem_addr[17:2]];
   always @(negedge clk) begin
      if (mem_we) mem[mem_addr[17:2]] <= mem_din;
   end

   task automatic cmp_word(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_bit(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: memory as individual bytes, accesses as byte runs.
   logic [7:0]  ref_bytes [0:1023];
   logic        m_wbv, m_errv, n_wbv, n_errv;
   logic [31:0] m_wbd, m_erra, n_wbd, n_erra;
   logic        pend;
   logic [31:0] p_addr, p_wdata;
   int          p_size;

   function automatic logic [31:0] ref_read(input logic [31:0] a, input int size, input bit sgn);
      logic [31:0] v;
      logic [9:0]  ix;
      v = 32'h0;
      for (int i = 0; i < size; i++) begin
         ix = a[9:0] + 10'(i);
         v  = v | (32'(ref_bytes[ix]) << (8 * i));
      end
      if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8 * size));
      return v;
   endfunction

   task automatic ref_write(input logic [31:0] a, input int size, input logic [31:0] d);
      logic [9:0] ix;
      for (int i = 0; i < size; i++) begin
         ix = a[9:0] + 10'(i);
         ref_bytes[ix] = d[8*i +: 8];
      end
   endtask

   always @(posedge clk) begin : compare
      int  size;
      bit  legal;
      logic e_stall, e_we;
      #3;
      if (!rst_n) begin
         m_wbv = 1'b0; m_wbd = 32'h0; m_errv = 1'b0; m_erra = 32'h0;
         pend = 1'b0;
      end
      cmp_bit ("wb_valid",  wb_valid,  m_wbv);
      cmp_word("wb_data",   wb_data,   m_wbd);
      cmp_bit ("err_valid", err_valid, m_errv);
      cmp_word("err_addr",  err_addr,  m_erra);
      e_stall = 1'b0;
      e_we    = 1'b0;
      n_wbv   = 1'b0;
      n_errv  = 1'b0;
      n_wbd   = m_wbd;
      n_erra  = m_erra;
      if (!rst_n) begin
         n_wbd  = 32'h0;
         n_erra = 32'h0;
      end else if (pend) begin
         e_we = 1'b1;
         ref_write(p_addr, p_size, p_wdata);
         cmp_word("merge_addr", mem_addr, p_addr);
         cmp_word("merge_din",  mem_din,  ref_read({p_addr[31:2], 2'b00}, 4, 1'b0));
         pend = 1'b0;
      end else if (req_valid) begin
         size  = (req_funct3[1:0] == 2'b00) ? 1 : (req_funct3[1:0] == 2'b01) ? 2 : 4;
         legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                 && !(req_we && req_funct3[2])
                 && ((req_addr % size) == 0);
         if (!legal) begin
            n_errv = 1'b1;
            n_erra = req_addr;
         end else if (!req_we) begin
            n_wbv = 1'b1;
            n_wbd = ref_read(req_addr, size, !req_funct3[2]);
            cmp_word("load_addr", mem_addr, req_addr);
         end else if (size == 4) begin
            e_we = 1'b1;
            ref_write(req_addr, 4, req_wdata);
            cmp_word("sw_addr", mem_addr, req_addr);
            cmp_word("sw_din",  mem_din,  req_wdata);
         end else begin
            e_stall = 1'b1;
            pend    = 1'b1;
            p_addr  = req_addr;
            p_size  = size;
            p_wdata = req_wdata;
         end
      end
      cmp_bit("stall",  stall,  e_stall);
      cmp_bit("mem_we", mem_we, e_we);
      m_wbv = n_wbv; m_wbd = n_wbd; m_errv = n_errv; m_erra = n_erra;
   end

   task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk);
      #1;
      req_valid  = v;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;
      mem[16'h0040]  = 32'h8899AABB;
      ref_bytes[256] = 8'hBB;
      ref_bytes[257] = 8'hAA;
      ref_bytes[258] = 8'h99;
      ref_bytes[259] = 8'h88;
      pend = 1'b0;
      m_wbv = 1'b0; m_wbd = 32'h0; m_errv = 1'b0; m_erra = 32'h0;
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;

      repeat (2) @(posedge clk);
      #3;
      cmp_bit ("rst_wb_valid", wb_valid, 1'b0);
      cmp_word("rst_wb_data",  wb_data,  32'h0);
      cmp_word("rst_err_addr", err_addr, 32'h0);
      cmp_bit ("rst_mem_we",   mem_we,   1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      drive(1'b1, 1'b0, 3'b000, 32'h101, 32'h0);        // lb
      #2; cmp_bit("lb_stall", stall, 1'b0);
      drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);        // lbu
      #2; cmp_bit("lb_wbv", wb_valid, 1'b1); cmp_word("lb_data", wb_data, 32'hFFFFFFAA);
      drive(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);        // lh
      #2; cmp_word("lbu_data", wb_data, 32'h00000088);
      drive(1'b1, 1'b0, 3'b101, 32'h100, 32'h0);        // lhu
      #2; cmp_word("lh_data", wb_data, 32'hFFFF8899);
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);        // lw
      #2; cmp_word("lhu_data", wb_data, 32'h0000AABB);
      drive(1'b1, 1'b1, 3'b001, 32'h102, 32'h00001234); // sh
      #2; cmp_word("lw_data", wb_data, 32'h8899AABB); cmp_bit("sh_stall", stall, 1'b1);
      drive(1'b1, 1'b0, 3'b011, 32'h200, 32'h0);        // junk during MERGE
      #2; cmp_bit("sh_we", mem_we, 1'b1); cmp_word("sh_din", mem_din, 32'h1234AABB);
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);        // lw after sh
      #2; cmp_bit("merge_ignores_req", err_valid, 1'b0);
      drive(1'b1, 1'b1, 3'b000, 32'h100, 32'h000000CC); // sb
      #2; cmp_word("lw_after_sh", wb_data, 32'h1234AABB); cmp_bit("sb_stall", stall, 1'b1);
      drive(1'b1, 1'b1, 3'b000, 32'h100, 32'h000000CC); // held sb in MERGE
      #2; cmp_word("sb_din", mem_din, 32'h1234AACC); cmp_bit("sb_merge_stall", stall, 1'b0);
      drive(1'b1, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF); // sw right after MERGE
      #2; cmp_bit("sw_stall", stall, 1'b0); cmp_bit("sw_we", mem_we, 1'b1);
      idle();
      #2; cmp_word("mem_100", mem[16'h0040], 32'h1234AACC);
      cmp_word("mem_104", mem[16'h0041], 32'hDEADBEEF);

      drive(1'b1, 1'b1, 3'b010, 32'h106, 32'h11111111); // misaligned sw
      #2; cmp_bit("bad_sw_we", mem_we, 1'b0);
      drive(1'b1, 1'b0, 3'b001, 32'h101, 32'h0);        // misaligned lh
      #2; cmp_bit("err1_valid", err_valid, 1'b1); cmp_word("err1_addr", err_addr, 32'h106);
      drive(1'b1, 1'b0, 3'b011, 32'h108, 32'h0);        // funct3=011 load
      #2; cmp_word("err2_addr", err_addr, 32'h101); cmp_bit("err2_wbv", wb_valid, 1'b0);
      drive(1'b1, 1'b1, 3'b100, 32'h10C, 32'h0);        // unsigned store is illegal
      #2; cmp_word("err3_addr", err_addr, 32'h108);
      idle();
      #2; cmp_bit("err4_valid", err_valid, 1'b1); cmp_word("err4_addr", err_addr, 32'h10C);
      idle();
      #2; cmp_bit("err_pulse_end", err_valid, 1'b0);
      cmp_word("mem_104_kept", mem[16'h0041], 32'hDEADBEEF);

      drive(1'b1, 1'b1, 3'b000, 32'h100, 32'h00000055); // sb, reset hits its MERGE
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2; cmp_bit("rstm_we", mem_we, 1'b0); cmp_bit("rstm_stall", stall, 1'b0);
      cmp_word("rstm_err_addr", err_addr, 32'h0);
      idle();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      #2; cmp_bit("post_rst_stall", stall, 1'b0);
      cmp_word("mem_100_unchanged", mem[16'h0040], 32'h1234AACC);
      idle();
      #2; cmp_word("post_rst_lw", wb_data, 32'h1234AACC);
      drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);        // lb of a positive byte
      idle();
      #2; cmp_word("lb_pos", wb_data, 32'h00000012);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
